// File: rtl/hdlc_rx_frame_ctrl.sv
// HDLC receive frame sequencer: turns flag/abort/byte strobes from the Rx datapath into
// registered frame control (valid window, buffer writes, EoF, abort, overflow, frame size).
module hdlc_rx_frame_ctrl #(
    parameter int MAX_BYTES = 128,
    parameter int FCS_BYTES = 2
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Rx_Enable,
    input  logic                         Rx_Drop,
    input  logic                         Rx_FlagDetect,
    input  logic                         Rx_AbortDetect,
    input  logic                         Rx_NewByte,
    input  logic [7:0]                   Rx_DataIn,
    output logic                         Rx_ValidFrame,
    output logic                         Rx_WrBuff,
    output logic [$clog2(MAX_BYTES)-1:0] Rx_WrAddr,
    output logic [7:0]                   Rx_DataBuff,
    output logic                         Rx_EoF,
    output logic                         Rx_AbortSignal,
    output logic                         Rx_Overflow,
    output logic                         Rx_FrameError,
    output logic [7:0]                   Rx_FrameSize
);

    localparam int AW = $clog2(MAX_BYTES);
    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BYTES);
    localparam logic [CW-1:0] CNT_FCS = CW'(FCS_BYTES);

    typedef enum logic [1:0] {IDLE, OPEN, FRAME, CLOSE} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] count, countNext;
    logic [CW-1:0] payload;
    logic          reopen, reopenNext;
    logic          validNext, wrNext, eofNext, abortNext, ovfNext, errNext;
    logic [AW-1:0] addrNext;
    logic [7:0]    dataNext, sizeNext;

    // count never exceeds MAX_BYTES, so the payload is already clipped to the buffer depth
    assign payload = (count > CNT_FCS) ? count - CNT_FCS : '0;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext  = state;
        countNext  = count;
        reopenNext = reopen;
        validNext  = Rx_ValidFrame;
        wrNext     = 1'b0;
        addrNext   = Rx_WrAddr;
        dataNext   = Rx_DataBuff;
        eofNext    = 1'b0;
        abortNext  = 1'b0;
        ovfNext    = Rx_Overflow;
        errNext    = Rx_FrameError;
        sizeNext   = Rx_FrameSize;

        unique case (state)
            IDLE: begin
                if (Rx_Enable && Rx_FlagDetect)
                    stateNext = OPEN;
            end
            OPEN: begin
                // Losing the enable or a drop between frames just falls back to hunting quietly
                if (!Rx_Enable || Rx_Drop || Rx_AbortDetect) begin
                    stateNext = IDLE;
                end else if (Rx_NewByte && !Rx_FlagDetect) begin
                    stateNext = FRAME;
                    validNext = 1'b1;
                    wrNext    = 1'b1;
                    addrNext  = '0;
                    dataNext  = Rx_DataIn;
                    ovfNext   = 1'b0;
                    errNext   = 1'b0;
                    countNext = CW'(1);
                end
            end
            FRAME: begin
                if (!Rx_Enable || Rx_Drop) begin
                    stateNext  = CLOSE;
                    reopenNext = 1'b0;
                    validNext  = 1'b0;
                    errNext    = 1'b1;
                end else if (Rx_AbortDetect) begin
                    stateNext  = CLOSE;
                    reopenNext = 1'b0;
                    validNext  = 1'b0;
                    abortNext  = 1'b1;
                end else if (Rx_FlagDetect) begin
                    stateNext  = CLOSE;
                    reopenNext = 1'b1;
                    validNext  = 1'b0;
                end else if (Rx_NewByte) begin
                    if (count < CNT_MAX) begin
                        wrNext    = 1'b1;
                        addrNext  = AW'(count);
                        dataNext  = Rx_DataIn;
                        countNext = count + CW'(1);
                    end else begin
                        ovfNext = 1'b1;
                    end
                end
            end
            CLOSE: begin
                eofNext   = 1'b1;
                sizeNext  = 8'(payload);
                countNext = '0;
                if (reopen && (count <= CNT_FCS))
                    errNext = 1'b1;
                // A closing flag doubles as the opening flag of the next frame
                stateNext = reopen ? OPEN : IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state          <= IDLE;
            count          <= '0;
            reopen         <= 1'b0;
            Rx_ValidFrame  <= 1'b0;
            Rx_WrBuff      <= 1'b0;
            Rx_WrAddr      <= '0;
            Rx_DataBuff    <= '0;
            Rx_EoF         <= 1'b0;
            Rx_AbortSignal <= 1'b0;
            Rx_Overflow    <= 1'b0;
            Rx_FrameError  <= 1'b0;
            Rx_FrameSize   <= '0;
        end else begin
            state          <= stateNext;
            count          <= countNext;
            reopen         <= reopenNext;
            Rx_ValidFrame  <= validNext;
            Rx_WrBuff      <= wrNext;
            Rx_WrAddr      <= addrNext;
            Rx_DataBuff    <= dataNext;
            Rx_EoF         <= eofNext;
            Rx_AbortSignal <= abortNext;
            Rx_Overflow    <= ovfNext;
            Rx_FrameError  <= errNext;
            Rx_FrameSize   <= sizeNext;
        end
    end

endmodule
